kernel3_gmem_b_m_axi_srl_fifo: RTL and testbench



---
 rtl/kernel3_gmem_b_m_axi_srl_fifo_pkg.sv | 10 +
 rtl/kernel3_gmem_b_m_axi_srl_fifo_srl.sv | 45 ++++
 rtl/kernel3_gmem_b_m_axi_srl_fifo.sv | 87 ++++++++
 tb/tb_kernel3_gmem_b_m_axi_srl_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel3_gmem_b_m_axi_srl_fifo_pkg.sv
// Shared helpers for the gmem_B show-ahead SRL FIFO.
package kernel3_gmem_b_m_axi_srl_fifo_pkg;

  // A usable configuration needs room for at least one SRL beat plus the output
  // register, and an SRL address range that can reach every SRL beat.
  function automatic bit fifo_params_ok(input int depth, input int addr_width);
    return (depth >= 2) && ((1 << addr_width) >= (depth - 1));
  endfunction

endpackage

// File: rtl/kernel3_gmem_b_m_axi_srl_fifo_srl.sv
// Shift-register store for the gmem_B FIFO. New beats enter at index 0 and age
// towards higher indices. A registered output holds the beat selected by raddr_i.
module kernel3_gmem_b_m_axi_srl_fifo_srl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-2];
  logic [DATA_WIDTH-1:0] dout_q;

  // Shift a new beat in at index 0 on every write.
  // NOTE: the shift array has no reset so it maps onto SRL primitives; the
  // controller's occupancy count decides which entries hold real data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH - 1; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Load the head register from the SRL; a same-edge shift does not disturb the
  // read because both sides see the pre-edge array contents.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (re_i) begin
      dout_q <= mem_q[raddr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/kernel3_gmem_b_m_axi_srl_fifo.sv
// Show-ahead FIFO controller for the gmem_B m_axi datapath. It tracks SRL
// occupancy and head validity, and it drives the SRL write, read and address.
module kernel3_gmem_b_m_axi_srl_fifo
  import kernel3_gmem_b_m_axi_srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] MEM_MAX = CNT_WIDTH'(DEPTH - 1);

  if (!fifo_params_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_params
    $error("kernel3_gmem_b_m_axi_srl_fifo: DEPTH must be >= 2 and fit in 2**ADDR_WIDTH + 1");
  end

  logic [CNT_WIDTH-1:0]  mem_cnt_q, mem_cnt_d;
  logic                  head_vld_q, head_vld_d;
  logic                  push, pop_out, re;
  logic [ADDR_WIDTH-1:0] raddr;

  // The full flag comes only from registered state, so if_read never reaches it
  // combinationally. This costs one bubble when a pop meets a full SRL.
  assign if_full_n = (mem_cnt_q != MEM_MAX);
  assign push      = clk_en & if_write & if_full_n;
  assign pop_out   = clk_en & if_read & head_vld_q;
  // The head refills whenever the SRL holds a beat and the head is empty or is
  // leaving this cycle.
  assign re        = clk_en & (mem_cnt_q != '0) & (~head_vld_q | if_read);
  // The oldest beat sits at the deepest occupied index. A full 2**ADDR_WIDTH
  // count wraps to the top address, which is still correct.
  assign raddr     = mem_cnt_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  // Next-state for occupancy and head validity. clk_en is folded into push, re
  // and pop_out, so a stall holds both values.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    mem_cnt_d  = mem_cnt_q;
    head_vld_d = re | (head_vld_q & ~pop_out);
    case ({push, re})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_WIDTH'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_WIDTH'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Controller state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
    end else begin
      mem_cnt_q  <= mem_cnt_d;
      head_vld_q <= head_vld_d;
    end
  end

  kernel3_gmem_b_m_axi_srl_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push),
    .re_i    (re),
    .raddr_i (raddr),
    .din_i   (if_din),
    .dout_o  (if_dout)
  );

  assign if_empty_n     = head_vld_q;
  assign num_data_valid = mem_cnt_q + CNT_WIDTH'(head_vld_q);

endmodule

// File: tb/tb_kernel3_gmem_b_m_axi_srl_fifo.sv
// Self-checking bench for the gmem_B show-ahead SRL FIFO. A queue model holds
// every beat in the FIFO. A single bit records whether the oldest beat is
// already visible at the output.
module tb_kernel3_gmem_b_m_axi_srl_fifo;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 63;

  logic          clk = 1'b0;
  logic          reset, clk_en, if_write, if_read;
  logic [DW-1:0] if_din, if_dout;
  logic          if_full_n, if_empty_n;
  logic [CW-1:0] num_data_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: all beats held, head visibility, and the last beat handed out.
  logic [DW-1:0] q[$];
  bit            hv;
  logic [DW-1:0] last_pop;

  always #5 clk = ~clk;

  kernel3_gmem_b_m_axi_srl_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .if_write       (if_write),
    .if_din         (if_din),
    .if_full_n      (if_full_n),
    .if_read        (if_read),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .num_data_valid (num_data_valid)
  );

  function automatic int model_backlog();
    return q.size() - int'(hv);
  endfunction

  function automatic logic exp_full_n();
    return model_backlog() != DEPTH - 1;
  endfunction

  function automatic logic [DW-1:0] exp_dout();
    return hv ? q[0] : last_pop;
  endfunction

  // Apply the FIFO rules to the model for one clock edge.
  task automatic model_step(input bit rst, input bit en, input bit wr, input bit rd,
                            input logic [DW-1:0] din);
    int backlog;
    bit acc_push, acc_pop, refill;
    if (rst) begin
      q.delete();
      hv       = 1'b0;
      last_pop = '0;
    end else if (en) begin
      backlog  = model_backlog();
      acc_push = wr && (backlog != DEPTH - 1);
      acc_pop  = rd && hv;
      refill   = (backlog != 0) && (!hv || rd);
      if (acc_pop) last_pop = q.pop_front();
      if (acc_push) q.push_back(din);
      hv = refill || (hv && !acc_pop);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, and settle past the edge.
  task automatic drive(input bit rst, input bit en, input bit wr, input bit rd,
                       input logic [DW-1:0] din);
    reset    = rst;
    clk_en   = en;
    if_write = wr;
    if_read  = rd;
    if_din   = din;
    @(posedge clk);
    model_step(rst, en, wr, rd, din);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    tests_run++;
    if (num_data_valid !== CW'(0)) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d want 0", num_data_valid);
    end
    tests_run++;
    if (if_empty_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_empty_n: got %b want 0", if_empty_n);
    end
    tests_run++;
    if (if_full_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_full_n: got %b want 1", if_full_n);
    end
    tests_run++;
    if (if_dout !== '0) begin
      tests_failed++;
      $display("FAIL reset_dout: got %h want 0", if_dout);
    end
  endtask

  task automatic test_latency();
    drive(1, 1, 0, 0, '0);
    drive(0, 1, 1, 0, 32'hA5A5_0001);
    tests_run++;
    if (if_empty_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_cycle1_empty_n: got %b want 0", if_empty_n);
    end
    drive(0, 1, 0, 0, '0);
    tests_run++;
    if (if_empty_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_cycle2_empty_n: got %b want 1", if_empty_n);
    end
    tests_run++;
    if (if_dout !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL latency_dout: got %h want a5a50001", if_dout);
    end
    tests_run++;
    if (num_data_valid !== CW'(1)) begin
      tests_failed++;
      $display("FAIL latency_count: got %0d want 1", num_data_valid);
    end
    // Pop the beat. The output should keep showing it after the FIFO goes empty.
    drive(0, 1, 0, 1, '0);
    tests_run++;
    if (if_empty_n !== 1'b0 || num_data_valid !== CW'(0)) begin
      tests_failed++;
      $display("FAIL latency_pop: got empty_n=%b count=%0d want 0/0", if_empty_n, num_data_valid);
    end
    tests_run++;
    if (if_dout !== 32'hA5A5_0001) begin
      tests_failed++;
      $display("FAIL latency_hold_dout: got %h want a5a50001", if_dout);
    end
  endtask

  task automatic test_fill_full();
    int e;
    int budget;
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1, 0, DW'(i));
      tests_run++;
      if (if_full_n !== exp_full_n()) begin
        tests_failed++;
        $display("FAIL fill_full_n push %0d: got %b want %b", i, if_full_n, exp_full_n());
      end
    end
    tests_run++;
    if (num_data_valid !== CW'(DEPTH) || if_full_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_at_capacity: got count=%0d full_n=%b want 63/0", num_data_valid, if_full_n);
    end
    // A push into the full FIFO is refused.
    drive(0, 1, 1, 0, 32'd999);
    tests_run++;
    if (num_data_valid !== CW'(DEPTH)) begin
      tests_failed++;
      $display("FAIL fill_overflow_count: got %0d want 63", num_data_valid);
    end
    e = 0;
    budget = 0;
    while (e < DEPTH && budget < 400) begin
      if (if_empty_n) begin
        tests_run++;
        if (if_dout !== DW'(e)) begin
          tests_failed++;
          $display("FAIL drain_order beat %0d: got %0d want %0d", e, if_dout, e);
        end
        e++;
      end
      drive(0, 1, 0, 1, '0);
      budget++;
    end
    tests_run++;
    if (e != DEPTH) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d beats want 63", e);
    end
    tests_run++;
    if (num_data_valid !== CW'(0) || if_empty_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: got count=%0d empty_n=%b want 0/0", num_data_valid, if_empty_n);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, DW'(i));
    drive(0, 1, 0, 0, '0);
    tests_run++;
    if (num_data_valid !== CW'(10)) begin
      tests_failed++;
      $display("FAIL b2b_prefill_count: got %0d want 10", num_data_valid);
    end
    for (int k = 0; k < 100; k++) begin
      tests_run++;
      if (if_empty_n !== 1'b1 || if_dout !== DW'(k)) begin
        tests_failed++;
        $display("FAIL b2b_head cycle %0d: got empty_n=%b dout=%0d want 1/%0d", k, if_empty_n, if_dout, k);
      end
      drive(0, 1, 1, 1, DW'(10 + k));
      tests_run++;
      if (num_data_valid !== CW'(10)) begin
        tests_failed++;
        $display("FAIL b2b_count cycle %0d: got %0d want 10", k, num_data_valid);
      end
    end
  endtask

  task automatic test_clk_en_stall();
    int frozen;
    logic [DW-1:0] seq;
    drive(1, 1, 0, 0, '0);
    seq = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, seq);
      seq++;
    end
    frozen = 0;
    for (int c = 0; c < 60; c++) begin
      bit en;
      en = !(c >= 20 && c < 25);
      if (c == 20) frozen = q.size();
      drive(0, en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), seq);
      seq++;
      tests_run++;
      if (if_dout !== exp_dout() || if_empty_n !== hv) begin
        tests_failed++;
        $display("FAIL stall_head cycle %0d: got dout=%h empty_n=%b want %h/%b", c, if_dout, if_empty_n, exp_dout(), hv);
      end
      tests_run++;
      if (num_data_valid !== CW'(q.size()) || if_full_n !== exp_full_n()) begin
        tests_failed++;
        $display("FAIL stall_count cycle %0d: got count=%0d full_n=%b want %0d/%b", c, num_data_valid, if_full_n, q.size(), exp_full_n());
      end
      if (!en) begin
        tests_run++;
        if (num_data_valid !== CW'(frozen)) begin
          tests_failed++;
          $display("FAIL stall_frozen cycle %0d: got %0d want %0d", c, num_data_valid, frozen);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < 40; i++) drive(0, 1, 1, 0, DW'(32'h200 + i));
    tests_run++;
    if (num_data_valid !== CW'(40)) begin
      tests_failed++;
      $display("FAIL midrst_prefill: got %0d want 40", num_data_valid);
    end
    drive(1, 1, 1, 1, 32'hDEAD_BEEF);
    tests_run++;
    if (num_data_valid !== CW'(0) || if_empty_n !== 1'b0 || if_full_n !== 1'b1 || if_dout !== '0) begin
      tests_failed++;
      $display("FAIL midrst_state: got count=%0d empty_n=%b full_n=%b dout=%h want 0/0/1/0",
               num_data_valid, if_empty_n, if_full_n, if_dout);
    end
    drive(0, 1, 1, 0, 32'd100);
    drive(0, 1, 1, 0, 32'd101);
    drive(0, 1, 1, 0, 32'd102);
    drive(0, 1, 0, 0, '0);
    tests_run++;
    if (if_empty_n !== 1'b1 || if_dout !== 32'd100 || num_data_valid !== CW'(3)) begin
      tests_failed++;
      $display("FAIL midrst_refill: got empty_n=%b dout=%0d count=%0d want 1/100/3",
               if_empty_n, if_dout, num_data_valid);
    end
  endtask

  task automatic test_random();
    drive(1, 1, 0, 0, '0);
    for (int c = 0; c < 10000; c++) begin
      drive(0, ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), DW'($urandom));
      tests_run++;
      if (if_empty_n !== hv || if_dout !== exp_dout()) begin
        tests_failed++;
        $display("FAIL rand_head cycle %0d: got empty_n=%b dout=%h want %b/%h", c, if_empty_n, if_dout, hv, exp_dout());
      end
      tests_run++;
      if (num_data_valid !== CW'(q.size()) || if_full_n !== exp_full_n()) begin
        tests_failed++;
        $display("FAIL rand_count cycle %0d: got count=%0d full_n=%b want %0d/%b", c, num_data_valid, if_full_n, q.size(), exp_full_n());
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    clk_en   = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = '0;
    hv       = 1'b0;
    last_pop = '0;
    test_reset();
    test_latency();
    test_fill_full();
    test_back_to_back();
    test_clk_en_stall();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
